// File: rtl/pipe_stage_buf.sv
// ============================================================================
// Module      : pipe_stage_buf
// Description : Generic inter-stage pipeline register with a valid/ready
//               handshake. A two-entry buffer (main + skid) sustains full
//               throughput under registered backpressure. It supports flush,
//               and it gates the control and rd outputs with valid so that an
//               empty slot never drives side effects.
//               Optional macro PIPE_STAGE_PERF_EN adds the stall_cnt and
//               bubble_cnt saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic                out_valid_q,  out_valid_d;
    logic                in_ready_q,   in_ready_d;
    logic [DATA_W-1:0]   main_data_q,  main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q,  main_ctrl_d;
    logic [RD_W-1:0]     main_rd_q,    main_rd_d;
    logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q,  skid_ctrl_d;
    logic [RD_W-1:0]     skid_rd_q,    skid_rd_d;

    logic                w_push;
    logic                w_pop;

    assign w_push = in_valid & in_ready_q;
    assign w_pop  = out_valid_q & out_ready;

    // Next-state and buffer-content selection; flush overrides every transition.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            main_rd_d   = '0;
            skid_ctrl_d = '0;
            skid_rd_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                    end else if (w_push) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_rd_d   = in_rd;
                    end else if (w_pop) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (w_pop) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_rd_d   = skid_rd_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State, buffers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    // Control and rd are forced to zero on a bubble so downstream writes never fire.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid_q}};
    assign out_rd    = main_rd_q   & {RD_W{out_valid_q}};

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    // Counter width has no hardware in this build.
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Directed self-checking bench for pipe_stage_buf. When
//               PIPE_STAGE_PERF_EN is defined, it also checks the counters
//               with CNT_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RD_W-1:0]   out_rd;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int n_total;
    int n_pass;

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_rd     (out_rd)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c, input logic [4:0] r);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_rd    = r;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 5'd0);

        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_out_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("rst_out_rd",    {27'd0, out_rd},    32'd0);
        step();
        step();
        rst = 1'b0;

        // Streaming: back-to-back beats with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 32'h10, 8'h11, 5'd1);
        step();
        chk("st0_valid", {31'd0, out_valid}, 32'd1);
        chk("st0_data",  out_data,           32'h10);
        chk("st0_ctrl",  {24'd0, out_ctrl},  32'h11);
        chk("st0_rd",    {27'd0, out_rd},    32'd1);
        chk("st0_ready", {31'd0, in_ready},  32'd1);
        drive(1'b1, 32'h20, 8'h22, 5'd2);
        step();
        chk("st1_data",  out_data,           32'h20);
        chk("st1_ready", {31'd0, in_ready},  32'd1);
        drive(1'b1, 32'h30, 8'h33, 5'd3);
        step();
        chk("st2_data",  out_data,           32'h30);
        chk("st2_rd",    {27'd0, out_rd},    32'd3);
        chk("st2_ready", {31'd0, in_ready},  32'd1);

        // Bubble: invalid input with non-zero control must not leak out
        drive(1'b0, 32'h0, 8'hFF, 5'd5);
        step();
        chk("bub_valid", {31'd0, out_valid}, 32'd0);
        chk("bub_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("bub_rd",    {27'd0, out_rd},    32'd0);
        chk("bub_hold",  out_data,           32'h30);

        // Backpressure: A, B fill the buffer, C waits upstream
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 8'hA1, 5'd10);
        step();
        chk("bp_a_data",  out_data,          32'hA);
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'hB, 8'hB1, 5'd11);
        step();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_data",  out_data,          32'hA);
        drive(1'b1, 32'hC, 8'hC1, 5'd12);
        step();
        chk("bp_stall_data",  out_data,          32'hA);
        chk("bp_stall_ctrl",  {24'd0, out_ctrl}, 32'hA1);
        chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b",     out_data,           32'hB);
        chk("bp_out_b_rd",  {27'd0, out_rd},    32'd11);
        chk("bp_ready_b",   {31'd0, in_ready},  32'd1);
        step();
        chk("bp_out_c",     out_data,           32'hC);
        chk("bp_out_c_rd",  {27'd0, out_rd},    32'd12);
        drive(1'b0, 32'h0, 8'h0, 5'd0);
        step();
        chk("bp_drain",     {31'd0, out_valid}, 32'd0);

        // Flush from FULL with a valid beat presented that must be dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 8'h01, 5'd1);
        step();
        drive(1'b1, 32'h2, 8'h02, 5'd2);
        step();
        chk("fl_pre_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'hD, 8'hDD, 5'd13);
        flush = 1'b1;
        step();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready},  32'd1);
        chk("fl_data",  out_data,           32'd0);
        chk("fl_ctrl",  {24'd0, out_ctrl},  32'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 5'd0);
        out_ready = 1'b1;
        step();
        chk("fl_no_d",  {31'd0, out_valid}, 32'd0);

        // Asynchronous reset from FULL
        out_ready = 1'b0;
        drive(1'b1, 32'hE, 8'hE1, 5'd14);
        step();
        drive(1'b1, 32'hF, 8'hF1, 5'd15);
        step();
        chk("ar_pre_full", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 32'h0, 8'h0, 5'd0);
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_ready", {31'd0, in_ready},  32'd1);
        chk("ar_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("ar_rd",    {27'd0, out_rd},    32'd0);
        step();
        rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Counters: one idle edge, then a beat held under stall for 9 edges
        drive(1'b1, 32'h55, 8'h55, 5'd5);
        step();
        chk("pf_bubble1", {29'd0, bubble_cnt}, 32'd1);
        chk("pf_stall0",  {29'd0, stall_cnt},  32'd0);
        drive(1'b0, 32'h0, 8'h0, 5'd0);
        for (int i = 0; i < 9; i++) begin
            step();
        end
        chk("pf_stall_sat", {29'd0, stall_cnt},  32'd7);
        chk("pf_bubble",    {29'd0, bubble_cnt}, 32'd1);
        chk("pf_held",      out_data,            32'h55);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("pf_flush_keep", {29'd0, stall_cnt}, 32'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
